// File: rtl/md_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Multi-cycle MULT/MULTU/DIV/DIVU with cancel, single-cycle MTHI/MTLO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  cnt;

  logic        sgn;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] result;
  logic        div_zero;

  assign busy = (state == RUN);

  // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    sgn      = ~op_q[0];
    prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    abs_a    = (sgn && a_q[31]) ? -a_q : a_q;
    abs_b    = (sgn && b_q[31]) ? -b_q : b_q;
    div_zero = (b_q == 32'd0);
    uq       = div_zero ? 32'd0 : abs_a / abs_b;
    ur       = div_zero ? 32'd0 : abs_a % abs_b;
    quot     = (sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
    rem      = (sgn && a_q[31]) ? -ur : ur;
    case (op_q)
      2'd0:    result = prod_s;
      2'd1:    result = prod_u;
      default: result = {rem, quot};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      cnt   <= 4'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q  <= md_op[1:0];
                a_q   <= A;
                b_q   <= B;
                cnt   <= md_op[1] ? DIV_N : MULT_N;
                state <= RUN;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt <= 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
            // Division by zero still burns the full period but leaves HI/LO alone.
            if (!(op_q[1] && div_zero)) begin
              HI <= result[63:32];
              LO <= result[31:0];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter: MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal 1..15).
REQ-002 Parameter: DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal 1..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  issue strobe from EX stage, one cycle per instruction.
REQ-006 Port: md_op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
REQ-007 Port: A  input  32  operand rs, forwarded register-file read data.
REQ-008 Port: B  input  32  operand rt, forwarded register-file read data.
REQ-009 Port: cancel  input  1  abort on exception/interrupt flush.
REQ-010 Port: busy  output  1  operation in flight; hazard logic stalls MD instructions on (start|busy).
REQ-011 Port: HI  output  32  architectural HI register.
REQ-012 Port: LO  output  32  architectural LO register.

Function
REQ-013 States: IDLE, RUN; busy SHALL be 1 exactly when state is RUN.
REQ-014 IDLE, start=1, md_op in {0..3}, cancel=0: latch op/operands, load counter with MULT_CYCLES or DIV_CYCLES, enter RUN on that edge.
REQ-015 Latency: start sampled at edge T -> busy=1 during cycles T+1..T+N; HI/LO updated at edge T+N, same edge busy falls; no extra idle cycle.
REQ-016 MULT: {HI,LO} = signed 32x32 -> 64 product; MULTU: unsigned 64-bit product.
REQ-017 DIV: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign.
REQ-018 DIVU: LO = unsigned quotient, HI = unsigned remainder.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no fault.
REQ-020 Divisor B=0 (DIV/DIVU): full DIV_CYCLES busy period; HI and LO SHALL retain prior values.
REQ-021 MTHI/MTLO with start=1 in IDLE: HI (resp. LO) <= A at that edge; busy stays 0; other register unchanged.
REQ-022 md_op 6/7 with start=1: no state change.
REQ-023 start=1 while RUN: ignored (hazard unit is required to prevent it); in-flight op unaffected.
REQ-024 Operands SHALL be captured at start; A/B changes during RUN have no effect.
REQ-025 cancel=1 during RUN: return to IDLE next edge, HI/LO keep pre-operation values, busy=0 from next cycle.
REQ-026 cancel=1 on the completion edge: cancel wins, HI/LO not written.
REQ-027 cancel=1 and start=1 same edge in IDLE: start ignored, including MTHI/MTLO.
REQ-028 HI/LO outputs SHALL be registered, never combinationally from in-flight results.
REQ-029 Counter width 4 bits; decrement once per cycle in RUN; no wrap below zero.

Reset
REQ-030 reset=1 SHALL immediately (asynchronously) force state IDLE, busy=0, counter=0, HI=0, LO=0.
REQ-031 reset mid-RUN: operation discarded; after release HI=LO=0 and block accepts start on first clean edge.
REQ-032 Reset SHALL take priority over start and cancel.

Verification
REQ-033 MULT A=0xFFFFFFFE (-2), B=0x00000003 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 leaves HI/LO unchanged.
REQ-036 MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 back-to-back -> busy never asserts; HI/LO updated on respective edges.
REQ-037 DIV started, cancel at busy cycle 4 -> busy=0 next cycle, HI/LO equal pre-start values; repeat with cancel on completion edge.
REQ-038 Async reset pulse between edges during MULT RUN -> busy, HI, LO drop to 0 without clock edge; new MULTU completes normally.
